// File: rtl/rs_station.sv
// Tomasulo reservation station: buffers micro-ops, snoops the CDB
// for operands and issues the oldest ready entry to its EX unit.
module rs_station #(
  parameter int ENTRIES = 4,
  parameter int DATA_W  = 32,
  parameter int TAG_W   = 4,
  parameter int OP_W    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      disp_valid,
  output logic                      disp_ready,
  input  logic [OP_W-1:0]           disp_op,
  input  logic [TAG_W-1:0]          disp_dst,
  input  logic                      disp_s1_rdy,
  input  logic [TAG_W-1:0]          disp_s1_tag,
  input  logic [DATA_W-1:0]         disp_s1_val,
  input  logic                      disp_s2_rdy,
  input  logic [TAG_W-1:0]          disp_s2_tag,
  input  logic [DATA_W-1:0]         disp_s2_val,
  input  logic                      cdb_valid,
  input  logic [TAG_W-1:0]          cdb_tag,
  input  logic [DATA_W-1:0]         cdb_val,
  output logic                      iss_valid,
  input  logic                      iss_ready,
  output logic [OP_W-1:0]           iss_op,
  output logic [TAG_W-1:0]          iss_dst,
  output logic [DATA_W-1:0]         iss_a,
  output logic [DATA_W-1:0]         iss_b,
  output logic [$clog2(ENTRIES):0]  count
);

  localparam int IW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam int CW = $clog2(ENTRIES) + 1;

  logic [ENTRIES-1:0] busy;
  logic [ENTRIES-1:0] q1_rdy;
  logic [ENTRIES-1:0] q2_rdy;
  logic [ENTRIES-1:0] rdy;
  logic [OP_W-1:0]    op     [ENTRIES];
  logic [TAG_W-1:0]   dst    [ENTRIES];
  logic [TAG_W-1:0]   q1_tag [ENTRIES];
  logic [TAG_W-1:0]   q2_tag [ENTRIES];
  logic [DATA_W-1:0]  v1     [ENTRIES];
  logic [DATA_W-1:0]  v2     [ENTRIES];
  logic [IW-1:0]      age    [ENTRIES];

  logic [IW-1:0]      slot;
  logic [IW-1:0]      sel;
  logic [IW-1:0]      sel_age;
  logic               disp_fire;
  logic               iss_fire;
  logic               s1_rdy;
  logic               s2_rdy;
  logic [DATA_W-1:0]  s1_val;
  logic [DATA_W-1:0]  s2_val;

  assign rdy = busy & q1_rdy & q2_rdy;

  always_comb begin
    count = '0;
    for (int i = 0; i < ENTRIES; i++)
      count = count + CW'(busy[i]);
  end

  // descending scan leaves the lowest free index
  always_comb begin
    slot = '0;
    for (int i = ENTRIES - 1; i >= 0; i--)
      if (!busy[i]) slot = IW'(i);
  end

  // strict compare keeps the lower index on a tie
  always_comb begin
    sel       = '0;
    sel_age   = '0;
    iss_valid = 1'b0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (rdy[i] && (!iss_valid || age[i] > sel_age)) begin
        sel       = IW'(i);
        sel_age   = age[i];
        iss_valid = 1'b1;
      end
    end
  end

  assign iss_op  = op[sel];
  assign iss_dst = dst[sel];
  assign iss_a   = v1[sel];
  assign iss_b   = v2[sel];

  assign disp_ready = !flush && (count < CW'(ENTRIES));
  assign disp_fire  = disp_valid && disp_ready;
  assign iss_fire   = iss_valid && iss_ready && !flush;

  assign s1_rdy = disp_s1_rdy ||
                  (cdb_valid && cdb_tag == disp_s1_tag);
  assign s2_rdy = disp_s2_rdy ||
                  (cdb_valid && cdb_tag == disp_s2_tag);
  assign s1_val = disp_s1_rdy ? disp_s1_val : cdb_val;
  assign s2_val = disp_s2_rdy ? disp_s2_val : cdb_val;

  // age counts younger busy entries, so it never exceeds ENTRIES-1
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      busy <= '0;
      for (int i = 0; i < ENTRIES; i++)
        age[i] <= '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (busy[i]) begin
          age[i] <= age[i] + IW'(disp_fire)
                    - IW'(iss_fire && age[i] > sel_age);
          if (cdb_valid && !q1_rdy[i] && q1_tag[i] == cdb_tag) begin
            q1_rdy[i] <= 1'b1;
            v1[i]     <= cdb_val;
          end
          if (cdb_valid && !q2_rdy[i] && q2_tag[i] == cdb_tag) begin
            q2_rdy[i] <= 1'b1;
            v2[i]     <= cdb_val;
          end
        end
      end
      if (iss_fire)
        busy[sel] <= 1'b0;
      if (disp_fire) begin
        busy[slot]   <= 1'b1;
        age[slot]    <= '0;
        op[slot]     <= disp_op;
        dst[slot]    <= disp_dst;
        q1_rdy[slot] <= s1_rdy;
        q1_tag[slot] <= disp_s1_tag;
        v1[slot]     <= s1_val;
        q2_rdy[slot] <= s2_rdy;
        q2_tag[slot] <= disp_s2_tag;
        v2[slot]     <= s2_val;
      end
    end
  end

endmodule

// File: tb/tb_rs_station.sv
// Bench for rs_station: directed vector table, then random traffic
// checked against a dispatch-ordered queue model.
module tb_rs_station;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst, flush, disp_valid, disp_ready;
  logic [3:0]  disp_op, disp_dst, disp_s1_tag, disp_s2_tag;
  logic        disp_s1_rdy, disp_s2_rdy;
  logic [31:0] disp_s1_val, disp_s2_val;
  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_val;
  logic        iss_valid, iss_ready;
  logic [3:0]  iss_op, iss_dst;
  logic [31:0] iss_a, iss_b;
  logic [2:0]  count;

  rs_station #(.ENTRIES(N)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_op(disp_op), .disp_dst(disp_dst),
    .disp_s1_rdy(disp_s1_rdy), .disp_s1_tag(disp_s1_tag),
    .disp_s1_val(disp_s1_val),
    .disp_s2_rdy(disp_s2_rdy), .disp_s2_tag(disp_s2_tag),
    .disp_s2_val(disp_s2_val),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_op(iss_op), .iss_dst(iss_dst),
    .iss_a(iss_a), .iss_b(iss_b), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit rs, fl, dv;
    logic [3:0] op, dst, t1, t2, ct;
    bit r1, r2, cv, ir;
    logic [31:0] v1, v2, cval;
  } in_t;

  typedef struct {
    bit ck, dr, iv, cd;
    logic [2:0] cnt;
    logic [3:0] op, dst;
    logic [31:0] a, b;
  } ex_t;

  typedef struct { in_t i; ex_t e; } vec_t;

  typedef struct {
    logic [3:0] op, dst, t1, t2;
    bit r1, r2;
    logic [31:0] v1, v2;
  } me_t;

  int n_vec = 0;
  int n_bad = 0;
  vec_t tv[$];
  me_t mq[$];

  function automatic in_t idle(bit ir);
    in_t x;
    x = '{default: '0};
    x.ir = ir;
    return x;
  endfunction

  function automatic in_t dsp(int op, int dst, bit r1, int t1,
      int v1, bit r2, int t2, int v2, bit ir);
    in_t x;
    x = idle(ir);
    x.dv = 1'b1;
    x.op = 4'(op);  x.dst = 4'(dst);
    x.r1 = r1; x.t1 = 4'(t1); x.v1 = 32'(v1);
    x.r2 = r2; x.t2 = 4'(t2); x.v2 = 32'(v2);
    return x;
  endfunction

  function automatic in_t cdb(in_t x, int t, int v);
    in_t y;
    y = x;
    y.cv = 1'b1; y.ct = 4'(t); y.cval = 32'(v);
    return y;
  endfunction

  function automatic ex_t nc();
    ex_t e;
    e = '{default: '0};
    return e;
  endfunction

  function automatic ex_t ex(bit dr, bit iv, int cnt);
    ex_t e;
    e = nc();
    e.ck = 1'b1; e.dr = dr; e.iv = iv; e.cnt = 3'(cnt);
    return e;
  endfunction

  function automatic ex_t exd(bit dr, int cnt, int op, int dst,
      int a, int b);
    ex_t e;
    e = ex(dr, 1'b1, cnt);
    e.cd = 1'b1;
    e.op = 4'(op); e.dst = 4'(dst); e.a = 32'(a); e.b = 32'(b);
    return e;
  endfunction

  function automatic vec_t vv(in_t i, ex_t e);
    vec_t v;
    v.i = i; v.e = e;
    return v;
  endfunction

  function automatic in_t rsi(in_t x);
    in_t y;
    y = x; y.rs = 1'b1;
    return y;
  endfunction

  function automatic in_t fli(in_t x);
    in_t y;
    y = x; y.fl = 1'b1;
    return y;
  endfunction

  task automatic drive(in_t x);
    rst = x.rs; flush = x.fl; disp_valid = x.dv;
    disp_op = x.op; disp_dst = x.dst;
    disp_s1_rdy = x.r1; disp_s1_tag = x.t1; disp_s1_val = x.v1;
    disp_s2_rdy = x.r2; disp_s2_tag = x.t2; disp_s2_val = x.v2;
    cdb_valid = x.cv; cdb_tag = x.ct; cdb_val = x.cval;
    iss_ready = x.ir;
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // oldest ready entry is the first ready one in dispatch order
  function automatic int msel();
    for (int i = 0; i < mq.size(); i++)
      if (mq[i].r1 && mq[i].r2) return i;
    return -1;
  endfunction

  task automatic model_step();
    int  s;
    bit  df;
    me_t m;
    s  = msel();
    df = disp_valid && (mq.size() < N);
    if (rst || flush) begin
      mq.delete();
    end else begin
      if (s >= 0 && iss_ready) mq.delete(s);
      if (cdb_valid) begin
        foreach (mq[i]) begin
          if (!mq[i].r1 && mq[i].t1 == cdb_tag) begin
            mq[i].r1 = 1'b1; mq[i].v1 = cdb_val;
          end
          if (!mq[i].r2 && mq[i].t2 == cdb_tag) begin
            mq[i].r2 = 1'b1; mq[i].v2 = cdb_val;
          end
        end
      end
      if (df) begin
        m.op = disp_op; m.dst = disp_dst;
        m.t1 = disp_s1_tag; m.t2 = disp_s2_tag;
        m.r1 = disp_s1_rdy || (cdb_valid && cdb_tag == disp_s1_tag);
        m.r2 = disp_s2_rdy || (cdb_valid && cdb_tag == disp_s2_tag);
        m.v1 = disp_s1_rdy ? disp_s1_val : cdb_val;
        m.v2 = disp_s2_rdy ? disp_s2_val : cdb_val;
        mq.push_back(m);
      end
    end
  endtask

  task automatic check_model();
    int s;
    s = msel();
    chk("rnd_disp_ready", 32'(disp_ready),
        32'(!flush && mq.size() < N));
    chk("rnd_count", 32'(count), 32'(mq.size()));
    chk("rnd_iss_valid", 32'(iss_valid), 32'(s >= 0));
    if (s >= 0 && iss_valid) begin
      chk("rnd_iss_op", 32'(iss_op), 32'(mq[s].op));
      chk("rnd_iss_dst", 32'(iss_dst), 32'(mq[s].dst));
      chk("rnd_iss_a", iss_a, mq[s].v1);
      chk("rnd_iss_b", iss_b, mq[s].v2);
    end
  endtask

  initial begin
    drive(idle(1'b0));

    // basic dispatch and issue
    tv.push_back(vv(rsi(idle(0)), nc()));
    tv.push_back(vv(idle(1), ex(1, 0, 0)));
    tv.push_back(vv(dsp(3, 5, 1, 0, 7, 1, 0, 9, 1), ex(1, 0, 0)));
    tv.push_back(vv(idle(1), exd(1, 1, 3, 5, 7, 9)));
    tv.push_back(vv(idle(1), ex(1, 0, 0)));
    // CDB wakeup, non-matching tag first
    tv.push_back(vv(dsp(1, 1, 0, 2, 0, 1, 0, 4, 1), ex(1, 0, 0)));
    tv.push_back(vv(cdb(idle(1), 3, 'h77), ex(1, 0, 1)));
    tv.push_back(vv(cdb(idle(1), 2, 'h55), ex(1, 0, 1)));
    tv.push_back(vv(idle(1), exd(1, 1, 1, 1, 'h55, 4)));
    tv.push_back(vv(idle(1), ex(1, 0, 0)));
    // dispatch/CDB bypass
    tv.push_back(vv(cdb(dsp(2, 3, 1, 0, 'h11, 0, 6, 0, 1), 6, 'hAA),
                    ex(1, 0, 0)));
    tv.push_back(vv(idle(1), exd(1, 1, 2, 3, 'h11, 'hAA)));
    tv.push_back(vv(idle(1), ex(1, 0, 0)));
    // fill, fifth dispatch refused, drain
    tv.push_back(vv(dsp(7, 8, 1, 0, 1, 1, 0, 17, 0), ex(1, 0, 0)));
    tv.push_back(vv(dsp(7, 9, 1, 0, 2, 1, 0, 18, 0),
                    exd(1, 1, 7, 8, 1, 17)));
    tv.push_back(vv(dsp(7, 10, 1, 0, 3, 1, 0, 19, 0),
                    exd(1, 2, 7, 8, 1, 17)));
    tv.push_back(vv(dsp(7, 11, 1, 0, 4, 1, 0, 20, 0),
                    exd(1, 3, 7, 8, 1, 17)));
    tv.push_back(vv(dsp(7, 12, 1, 0, 5, 1, 0, 21, 0),
                    exd(0, 4, 7, 8, 1, 17)));
    tv.push_back(vv(idle(1), exd(0, 4, 7, 8, 1, 17)));
    tv.push_back(vv(idle(0), exd(1, 3, 7, 9, 2, 18)));
    tv.push_back(vv(idle(1), exd(1, 3, 7, 9, 2, 18)));
    tv.push_back(vv(idle(1), exd(1, 2, 7, 10, 3, 19)));
    tv.push_back(vv(idle(1), exd(1, 1, 7, 11, 4, 20)));
    tv.push_back(vv(idle(1), ex(1, 0, 0)));
    // older waiting entry overtakes a held younger one
    tv.push_back(vv(dsp(4, 1, 0, 1, 0, 1, 0, 'h44, 0), ex(1, 0, 0)));
    tv.push_back(vv(dsp(5, 2, 1, 0, 'h22, 1, 0, 'h23, 0),
                    ex(1, 0, 1)));
    tv.push_back(vv(idle(0), exd(1, 2, 5, 2, 'h22, 'h23)));
    tv.push_back(vv(cdb(idle(0), 1, 'h33),
                    exd(1, 2, 5, 2, 'h22, 'h23)));
    tv.push_back(vv(idle(0), exd(1, 2, 4, 1, 'h33, 'h44)));
    tv.push_back(vv(idle(1), exd(1, 2, 4, 1, 'h33, 'h44)));
    tv.push_back(vv(idle(1), exd(1, 1, 5, 2, 'h22, 'h23)));
    tv.push_back(vv(idle(1), ex(1, 0, 0)));
    // flush beats dispatch and issue
    tv.push_back(vv(dsp(8, 1, 0, 9, 0, 1, 0, 1, 0), ex(1, 0, 0)));
    tv.push_back(vv(dsp(8, 2, 1, 0, 2, 1, 0, 3, 0), ex(1, 0, 1)));
    tv.push_back(vv(fli(dsp(8, 3, 1, 0, 4, 1, 0, 5, 1)),
                    exd(0, 2, 8, 2, 2, 3)));
    tv.push_back(vv(idle(1), ex(1, 0, 0)));
    tv.push_back(vv(idle(1), ex(1, 0, 0)));
    // reset during a stall beats dispatch
    tv.push_back(vv(dsp(6, 4, 1, 0, 1, 1, 0, 2, 0), ex(1, 0, 0)));
    tv.push_back(vv(rsi(dsp(6, 5, 1, 0, 3, 1, 0, 4, 0)),
                    exd(1, 1, 6, 4, 1, 2)));
    tv.push_back(vv(idle(1), ex(1, 0, 0)));

    foreach (tv[k]) begin
      @(negedge clk);
      drive(tv[k].i);
      #1;
      if (tv[k].e.ck) begin
        chk($sformatf("v%0d_disp_ready", k), 32'(disp_ready),
            32'(tv[k].e.dr));
        chk($sformatf("v%0d_iss_valid", k), 32'(iss_valid),
            32'(tv[k].e.iv));
        chk($sformatf("v%0d_count", k), 32'(count),
            32'(tv[k].e.cnt));
      end
      if (tv[k].e.cd) begin
        chk($sformatf("v%0d_iss_op", k), 32'(iss_op),
            32'(tv[k].e.op));
        chk($sformatf("v%0d_iss_dst", k), 32'(iss_dst),
            32'(tv[k].e.dst));
        chk($sformatf("v%0d_iss_a", k), iss_a, tv[k].e.a);
        chk($sformatf("v%0d_iss_b", k), iss_b, tv[k].e.b);
      end
      model_step();
    end

    for (int c = 0; c < 3000; c++) begin
      in_t x;
      x.rs   = ($urandom_range(149) == 0);
      x.fl   = ($urandom_range(39) == 0);
      x.dv   = ($urandom_range(1) == 1);
      x.op   = 4'($urandom);
      x.dst  = 4'($urandom);
      x.r1   = ($urandom_range(2) == 0);
      x.t1   = 4'($urandom_range(3));
      x.v1   = $urandom;
      x.r2   = ($urandom_range(2) == 0);
      x.t2   = 4'($urandom_range(3));
      x.v2   = $urandom;
      x.cv   = ($urandom_range(1) == 1);
      x.ct   = 4'($urandom_range(4));
      x.cval = $urandom;
      x.ir   = ($urandom_range(2) != 0);
      @(negedge clk);
      drive(x);
      #1;
      check_model();
      model_step();
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/rs_station.md
Name: rs_station

Overview:
- Parametrised reservation station for the Tomasulo back end. One instance per functional-unit class (add, mul, lw, sw, mv).
- Buffers dispatched micro-ops and snoops the CDB to capture missing operands.
- Issues the oldest fully-ready entry to its EX unit over a valid/ready handshake.
- Supports whole-station flush.

Parameters:
- ENTRIES, 4, number of station entries (2..16).
- DATA_W, 32, operand/result width.
- TAG_W, 4, producer tag width (ROB/RS tag on CDB).
- OP_W, 4, opcode field width passed to EX.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous clear of all entries.
- disp_valid  in  1  dispatch request.
- disp_ready  out  1  station can accept a dispatch this cycle.
- disp_op  in  OP_W  opcode.
- disp_dst  in  TAG_W  destination tag.
- disp_s1_rdy  in  1  src1 value present.
- disp_s1_tag  in  TAG_W  src1 producer tag when not present.
- disp_s1_val  in  DATA_W  src1 value when present.
- disp_s2_rdy, disp_s2_tag, disp_s2_val  in  1/TAG_W/DATA_W  same for src2 (immediate arrives as rdy=1).
- cdb_valid  in  1  CDB broadcast valid.
- cdb_tag  in  TAG_W  broadcast tag.
- cdb_val  in  DATA_W  broadcast value.
- iss_valid  out  1  selected entry offered to EX.
- iss_ready  in  1  EX accepts.
- iss_op  out  OP_W  opcode of offered entry.
- iss_dst  out  TAG_W  destination tag.
- iss_a  out  DATA_W  src1 value.
- iss_b  out  DATA_W  src2 value.
- count  out  clog2(ENTRIES)+1  busy entries.

Behaviour:
- Per-entry state: busy, op, dst, q1_rdy/q1_tag/v1, q2_rdy/q2_tag/v2, age.
- rst: all busy=0, ages=0. Data fields are don't-care. After reset: disp_ready=1, iss_valid=0, count=0.
- disp_ready = !flush && (count < ENTRIES). It is computed only from registered busy bits. An entry freed by issue in cycle N is not reusable until N+1.
- Dispatch fires on disp_valid && disp_ready.
  - Writes the lowest-index free entry.
  - New entry gets age=0. Every other busy entry increments its age.
- CDB wakeup: every cycle with cdb_valid, each busy entry with qX_rdy=0 and qX_tag==cdb_tag sets qX_rdy=1 and vX=cdb_val.
- Dispatch/CDB bypass: if a dispatching source has rdy=0 and its tag matches the same-cycle cdb_tag (cdb_valid=1), the entry is written with that source ready and holding cdb_val.
- Ready entry = busy && q1_rdy && q2_rdy.
- Issue select (combinational from registered state):
  - iss_valid = any ready entry.
  - Offered entry is the ready entry with the largest age; ties go to the lower index.
  - iss_* outputs show that entry's fields. When iss_valid=0 they are don't-care, but must be stable.
- Issue fires on iss_valid && iss_ready: the offered entry's busy clears at the edge.
- Back-pressure: while iss_valid && !iss_ready, the offered entry holds. If a dispatch or wakeup leaves that entry oldest-ready, it stays selected.
- Latency:
  - Dispatch with both sources ready at edge N gives iss_valid no earlier than cycle N+1.
  - CDB wakeup completing an entry at edge N makes it eligible in N+1.
- Simultaneous events in one cycle (dispatch + issue + CDB) are all applied. count_next = count + dispatch − issue.
- Ages stay distinct among busy entries; the maximum is ENTRIES−1, so no saturation is needed.
- flush: clears all busy and ages at the edge, takes priority over dispatch, and the issue handshake is ignored that cycle. iss_valid is 0 from the next cycle.
- rst has priority over flush. Reset mid-operation discards all entries, including an entry being offered.
- CDB tags matching no waiting source are ignored. A tag matching several entries wakes all of them.

Test Plan:
- Reset, then dispatch op=3, dst=5, s1=7, s2=9, both ready, with iss_ready=1 → cycle N+1: iss_valid=1, iss_a=7, iss_b=9, iss_dst=5. Cycle N+2: count=0.
- Dispatch an entry waiting on s1_tag=2. Two cycles later drive cdb_valid, tag=2, val=0x55 → iss_valid rises the next cycle with iss_a=0x55. Also drive a non-matching tag=3 → no change.
- Same-cycle bypass: dispatch with s2_rdy=0, s2_tag=6 while cdb_tag=6, val=0xAA → entry issues next cycle with iss_b=0xAA and never waits.
- Fill all 4 entries with iss_ready=0 → disp_ready=0, count=4, a fifth disp_valid is ignored. Issue one → disp_ready=1 in the cycle after the issue edge.
- Dispatch A (waiting on tag 1), then B (ready). B is offered. Wake A, hold iss_ready=0, then release it → A issues before B (older). With both ready, ties resolve oldest first.
- Two busy entries plus dispatch and flush in the same cycle → next cycle count=0, iss_valid=0, and the dispatched op is absent. Assert rst mid-stall → same result.
